// File: rtl/oct_pkg.sv
// Shared definitions for the multi-channel octave generator: default widths,
// the octave shift encoding and the saturating adder used by the output mix.
package oct_pkg;

    // Default configuration of oct_gen_multi.
    localparam int unsigned DefNCh   = 2;
    localparam int unsigned DefCntW  = 32;
    localparam int unsigned DefDataW = 12;
    localparam int unsigned DefAmpW  = 12;

    // Octave shift: each step halves the half-period (one octave up).
    typedef enum logic [1:0] {
        ShDiv1 = 2'd0,
        ShDiv2 = 2'd1,
        ShDiv4 = 2'd2,
        ShDiv8 = 2'd3
    } oct_shift_e;

    // Unsigned add clamped to 2^width-1. Operands are non-negative, so clamping
    // once at the end equals clamping after every partial sum.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] s;
        logic [64:0] max_v;
        s     = {1'b0, a} + {1'b0, b};
        max_v = (65'd1 << width) - 65'd1;
        return (s > max_v) ? max_v[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/oct_channel.sv
// One octave square-wave channel: captures a new limit on load, holds it as a
// pending update and applies it glitch-free at the next phase boundary.
import oct_pkg::*;

module oct_channel #(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             CLK_in,
    input  logic             RST_in,
    input  logic [CNT_W-1:0] periodo_in,
    input  logic [1:0]       shift_in,
    input  logic             load_in,
    output logic             pend_out,
    output logic             osc_out
);

    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] plim_q, plim_d;
    logic             osc_q, osc_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] new_lim;
    logic             running;
    logic             wrap;

    assign running = (lim_q != '0);
    assign wrap    = running && (cnt_q == lim_q);

    // Limit candidate from the live inputs, only used when load_in is high.
    always_comb begin
        new_lim = periodo_in;
        unique case (oct_shift_e'(shift_in))
            ShDiv1: new_lim = periodo_in;
            ShDiv2: new_lim = periodo_in >> 1;
            ShDiv4: new_lim = periodo_in >> 2;
            ShDiv8: new_lim = periodo_in >> 3;
        endcase
    end

    // Next-state: mute, wrap/apply, count, capture.
    always_comb begin
        lim_d  = lim_q;
        cnt_d  = cnt_q;
        osc_d  = osc_q;
        plim_d = plim_q;
        pend_d = pend_q;
        if (load_in && (new_lim == '0)) begin
            // A zero limit mutes at once, whatever the phase.
            lim_d  = '0;
            cnt_d  = '0;
            osc_d  = 1'b0;
            plim_d = '0;
            pend_d = 1'b0;
        end else if (running) begin
            if (wrap) begin
                cnt_d = '0;
                osc_d = ~osc_q;
                if (load_in) begin
                    // Load on the wrap cycle bypasses the pending stage.
                    lim_d  = new_lim;
                    plim_d = new_lim;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    lim_d  = plim_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (load_in) begin
                    plim_d = new_lim;
                    pend_d = 1'b1;
                end
            end
        end else begin
            // Muted: hold phase at zero; a pending update starts it next cycle.
            cnt_d = '0;
            osc_d = 1'b0;
            if (load_in) begin
                plim_d = new_lim;
                pend_d = 1'b1;
            end else if (pend_q) begin
                lim_d  = plim_q;
                pend_d = 1'b0;
            end
        end
    end

    // State register with synchronous reset; reset drops any pending update.
    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            lim_q  <= '0;
            cnt_q  <= '0;
            osc_q  <= 1'b0;
            plim_q <= '0;
            pend_q <= 1'b0;
        end else begin
            lim_q  <= lim_d;
            cnt_q  <= cnt_d;
            osc_q  <= osc_d;
            plim_q <= plim_d;
            pend_q <= pend_d;
        end
    end

    assign pend_out = pend_q;
    assign osc_out  = osc_q;

endmodule

// File: rtl/oct_gen_multi.sv
// Multi-channel octave square-wave synthesiser: N_CH oct_channel instances
// whose amplitude levels are summed with saturation into one DAC word.
// Define OCT_ADC_MIX_EN to add the adc_in sample into the mix.
import oct_pkg::*;

module oct_gen_multi #(
    parameter int unsigned N_CH   = DefNCh,
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned AMP_W  = DefAmpW
) (
    input  logic                  CLK_in,
    input  logic                  RST_in,
    input  logic [N_CH*CNT_W-1:0] periodo_in,
    input  logic [N_CH*2-1:0]     shift_in,
    input  logic [N_CH*AMP_W-1:0] amp_in,
    input  logic [N_CH-1:0]       load_in,
`ifdef OCT_ADC_MIX_EN
    input  logic [DATA_W-1:0]     adc_in,
`endif
    output logic [N_CH-1:0]       pend_out,
    output logic [N_CH-1:0]       osc_out,
    output logic [DATA_W-1:0]     data_oct
);

    // Wide enough for N_CH channel levels plus the optional ADC term.
    localparam int unsigned SumW = DATA_W + $clog2(N_CH + 1);

    logic [SumW-1:0]   sum;
    logic [63:0]       extra;
    logic [DATA_W-1:0] data_d, data_q;

    for (genvar k = 0; k < N_CH; k++) begin : gen_ch
        oct_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .CLK_in     (CLK_in),
            .RST_in     (RST_in),
            .periodo_in (periodo_in[k*CNT_W +: CNT_W]),
            .shift_in   (shift_in[k*2 +: 2]),
            .load_in    (load_in[k]),
            .pend_out   (pend_out[k]),
            .osc_out    (osc_out[k])
        );
    end

`ifdef OCT_ADC_MIX_EN
    assign extra = 64'(adc_in);
`else
    assign extra = '0;
`endif

    // Sum the live amplitudes of channels whose square wave is high, then clamp.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (osc_out[k]) begin
                sum = sum + SumW'(amp_in[k*AMP_W +: AMP_W]);
            end
        end
        data_d = DATA_W'(sat_add(64'(sum), extra, DATA_W));
    end

    // Output register towards the DAC.
    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_oct = data_q;

endmodule

// File: doc/oct_gen_multi.md
# oct_gen_multi

- Parametrised multi-channel octave square-wave synthesiser; successor to the single-channel octave generator.
- Each channel has its own half-period, octave shift and amplitude. Channels are summed with saturation into one DAC-width word.
- Period and shift updates are glitch-free: they are applied at a phase boundary.
- Sits between the frequency-measurement logic (source of `periodo_in`) and the DAC interface.

## Interface
- `N_CH`, 2: number of channels (1..8).
- `CNT_W`, 32: period counter width.
- `DATA_W`, 12: DAC word width.
- `AMP_W`, 12: per-channel amplitude width (≤ `DATA_W`).
- `CLK_in`  in  1: system clock; all logic on the rising edge.
- `RST_in`  in  1: synchronous, active-high reset.
- `periodo_in`  in  `N_CH*CNT_W`: per-channel base half-period; channel k at `[k*CNT_W +: CNT_W]`.
- `shift_in`  in  `N_CH*2`: per-channel octave shift, 0..3.
- `amp_in`  in  `N_CH*AMP_W`: per-channel high level; sampled live every cycle.
- `load_in`  in  `N_CH`: per-channel one-cycle strobe that captures `periodo_in`/`shift_in`.
- `adc_in`  in  `DATA_W`: original sample to mix. Present only with `OCT_ADC_MIX_EN`.
- `pend_out`  out  `N_CH`: channel k has a captured update not yet applied.
- `osc_out`  out  `N_CH`: raw square-wave state per channel.
- `data_oct`  out  `DATA_W`: registered, saturated mix to the DAC.

## Operation
- **Limit:** L = `periodo >> shift`, computed at capture and stored `CNT_W` wide. L == 0 means muted.
- **Per-channel state:** active limit `lim`, counter `cnt`, `osc`, pending limit `plim`, flag `pend`.
- **Running** (`lim` ≠ 0):
  - Wrap when `cnt == lim`: `osc` toggles and `cnt` goes to 0. Otherwise `cnt` increments.
  - Half-period = `lim`+1 cycles; full period = 2·(`lim`+1).
- **Muted** (`lim` == 0): `osc` = 0 and `cnt` = 0, both held.
- **Capture** (`load_in[k]`): `plim` ← L and `pend` ← 1. A new load while `pend` is set overwrites `plim`; only the last value counts.
- **Apply rules for a pending update:**
  - Channel running, new L ≠ 0: applied on the next wrap. `lim` ← `plim` and `pend` ← 0; the toggle at that wrap still happens.
  - Channel muted: applied on the next cycle. `cnt` = 0 and `osc` = 0, so the first rising toggle comes after L+1 cycles.
  - New L == 0: applied on the next cycle regardless of phase, i.e. immediate mute.
  - Load coinciding with a wrap: the new L is used at that same wrap (bypass); `pend` never asserts.
- **Mix:**
  - level_k = `osc_k` ? `amp_k` : 0.
  - sum = Σ level_k (+ `adc_in` with the macro), computed at width `DATA_W`+$clog2(`N_CH`+1).
  - `data_oct` = min(sum, 2^`DATA_W`−1).
- **Reset:** all `osc`, `cnt`, `lim`, `plim`, `pend` = 0 and `data_oct` = 0; every channel is muted. Reset mid-operation discards pending updates.

## Timing
- `osc_out` changes on the clock edge where `cnt == lim`.
- `data_oct` reflects `osc`/`amp_in` (and `adc_in`) one cycle later.
- `load_in` → `pend_out` high: 1 cycle. The bypass case is the exception.
- Muted channel: `load_in` → `lim` valid: 2 cycles. First `osc` rise after that: L+1 further cycles.
- No backpressure; `load_in` may be asserted on any cycle, on several channels at once.

## Configuration
- `OCT_ADC_MIX_EN` defined:
  - `adc_in` port exists and is added into the saturating sum.
  - The output is the octaved mix ready for the DAC.
- Not defined:
  - Port absent; the output is the channel sum only.
  - The saturation logic is unchanged.

## Structure
- Package `oct_pkg`: default widths, the shift encoding (0..3 = ÷1..÷8), and a saturating-add function.
- Sub-module `oct_channel`: one per channel, covering capture, pending/apply, counter and osc. The top does the mixing and the output register.

## Test plan
- **Basic toggle:** reset, then ch0 `periodo`=3, `shift`=0, `amp`=0x0FF, load.
  - `osc_out[0]` rises after 4 cycles and toggles every 4 cycles.
  - `data_oct` alternates 0x0FF/0x000, lagging by 1 cycle.
- **Octave shift:** ch0 `periodo`=15, `shift`=2 → L=3; same waveform as the basic toggle. `shift`=3 with `periodo`=7 → L=0 → muted, `data_oct` stays 0.
- **Glitch-free change:** ch0 running with L=9, load L=4 at `cnt`=2.
  - `pend_out[0]` is high until the wrap at `cnt`=9.
  - Subsequent half-periods are 5 cycles, with no short pulse.
- **Immediate mute:** ch1 running, load `periodo`=0 → next cycle `osc_out[1]`=0 and `pend_out[1]`=0.
- **Saturation:** `amp0`=`amp1`=0xC00, both high → `data_oct`=0xFFF. With `OCT_ADC_MIX_EN`, `adc_in`=0x800 and one channel at 0x900 high → 0xFFF.
- **Reset mid-run with pending update:** `RST_in` 1 cycle → next cycle all outputs 0 and `pend_out`=0; channels stay muted until reloaded.
